// File: rtl/iodelay_ctrl_pkg.sv
// Shared types for the RGMII RX IDELAY tap controller.
// State encoding, command bundle and a safe clog2 helper.
package iodelay_ctrl_pkg;

  localparam int iodelay_tap_width_gp  = 5;
  localparam int iodelay_lane_width_gp = 3;

  typedef enum logic [2:0] {
    RST,
    WAIT_RDY,
    INIT,
    IDLE,
    LOAD,
    VERIFY,
    RESP
  } state_e;

  typedef struct packed {
    logic [iodelay_lane_width_gp-1:0] lane;
    logic [iodelay_tap_width_gp-1:0]  tap;
  } iodelay_cmd_s;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iodelay_tap_ctrl_sync.sv
// Two-flop synchronizer for signals arriving async to clk_i.
// Resets low so downstream logic sees "not ready" after reset.
module iodelay_tap_ctrl_sync #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] d_o
);

  logic [width_p-1:0] s1_q;
  logic [width_p-1:0] s2_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign d_o = s2_q;

endmodule

// File: rtl/iodelay_tap_ctrl.sv
// IDELAYCTRL/IDELAYE2 bank sequencer: RST pulse, RDY wait,
// default tap init, then verified runtime tap loads.
module iodelay_tap_ctrl
  import iodelay_ctrl_pkg::*;
#(
  parameter int num_lanes_p       = 5,
  parameter int tap_width_p       = iodelay_tap_width_gp,
  parameter int init_tap_p        = 0,
  parameter int rst_hold_cycles_p = 16,
  parameter int rdy_timeout_p     = 1024,
  localparam int lane_w_lp = safe_clog2(num_lanes_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               idelayctrl_rdy_i,
  output logic                               idelayctrl_rst_o,
  output logic [num_lanes_p-1:0]             idelay_ld_o,
  output logic [tap_width_p-1:0]             idelay_cntvalue_o,
  input  logic [num_lanes_p*tap_width_p-1:0] idelay_cntvalue_i,
  input  logic                               cmd_v_i,
  input  logic [lane_w_lp-1:0]               cmd_lane_i,
  input  logic [tap_width_p-1:0]             cmd_tap_i,
  output logic                               cmd_ready_o,
  output logic                               resp_v_o,
  output logic                               resp_err_o,
  input  logic                               resp_ready_i,
  output logic                               calibrated_o,
  output logic                               timeout_err_o
);

  localparam int cnt_w_lp =
    $clog2(rdy_timeout_p + rst_hold_cycles_p + num_lanes_p + 1);

  state_e                   state_q;
  logic [cnt_w_lp-1:0]      cnt_q;
  iodelay_cmd_s             cmd_q;
  logic                     rst_q;
  logic [num_lanes_p-1:0]   ld_q;
  logic [tap_width_p-1:0]   cval_q;
  logic                     err_q;
  logic                     tmo_q;

  logic                     rdy_s;
  logic                     cal;
  logic                     rdy_loss;
  logic [num_lanes_p-1:0]   cmd_oh;
  logic [num_lanes_p-1:0]   lane_hit;
  logic [tap_width_p-1:0]   rb;

  iodelay_tap_ctrl_sync #(.width_p(1)) u_rdy_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (idelayctrl_rdy_i),
    .d_o       (rdy_s)
  );

  assign cal = state_q inside {IDLE, LOAD, VERIFY, RESP};
  assign rdy_loss = cal && !rdy_s;

  always_comb begin
    cmd_oh   = '0;
    lane_hit = '0;
    rb       = '0;
    for (int i = 0; i < num_lanes_p; i++) begin
      cmd_oh[i]   = (cmd_lane_i == lane_w_lp'(i));
      lane_hit[i] = (cmd_q.lane == lane_w_lp'(i));
      if (lane_hit[i])
        rb = idelay_cntvalue_i[i*tap_width_p +: tap_width_p];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RST;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rst_q   <= 1'b1;
      ld_q    <= '0;
      cval_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else if (rdy_loss) begin
      // Bank lost lock: drop any in-flight command silently.
      state_q <= RST;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RST: begin
          if (cnt_q == cnt_w_lp'(rst_hold_cycles_p - 1)) begin
            state_q <= WAIT_RDY;
            rst_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_RDY: begin
          if (rdy_s) begin
            state_q <= INIT;
            ld_q    <= num_lanes_p'(1);
            cval_q  <= tap_width_p'(init_tap_p);
            cnt_q   <= cnt_w_lp'(1);
          end else if (cnt_q == cnt_w_lp'(rdy_timeout_p - 1)) begin
            state_q <= RST;
            tmo_q   <= 1'b1;
            rst_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        INIT: begin
          if (cnt_q == cnt_w_lp'(num_lanes_p)) begin
            state_q <= IDLE;
            ld_q    <= '0;
            cnt_q   <= '0;
          end else begin
            ld_q  <= ld_q << 1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (cmd_v_i) begin
            state_q <= LOAD;
            cmd_q   <= '{lane: cmd_lane_i, tap: cmd_tap_i};
            ld_q    <= cmd_oh;
            if (|cmd_oh)
              cval_q <= cmd_tap_i;
          end
        end
        LOAD: begin
          state_q <= VERIFY;
          ld_q    <= '0;
        end
        VERIFY: begin
          state_q <= RESP;
          err_q   <= ~|lane_hit | (rb != cmd_q.tap);
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= RST;
      endcase
    end
  end

  assign idelayctrl_rst_o  = rst_q;
  assign idelay_ld_o       = ld_q;
  assign idelay_cntvalue_o = cval_q;
  assign cmd_ready_o       = (state_q == IDLE);
  assign resp_v_o          = (state_q == RESP);
  assign resp_err_o        = err_q;
  assign calibrated_o      = cal;
  assign timeout_err_o     = tmo_q;

endmodule

// File: tb/tb_iodelay_tap_ctrl.sv
// Scoreboard bench for iodelay_tap_ctrl: LD strobes and responses
// are queued by stimulus and popped by an independent monitor.
module tb_iodelay_tap_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rdy;
  logic        rst_o;
  logic [4:0]  ld_o;
  logic [4:0]  cval_o;
  logic [24:0] cv_i;
  logic        cmd_v;
  logic [2:0]  cmd_lane;
  logic [4:0]  cmd_tap;
  logic        cmd_ready;
  logic        resp_v;
  logic        resp_err;
  logic        resp_ready;
  logic        cal;
  logic        tmo;
  logic        corrupt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0] ld;
    logic [4:0] cv;
  } ld_t;

  ld_t  ldq[$];
  logic respq[$];
  ld_t  e;
  logic [4:0] tap_m [5];

  always #5 clk = ~clk;

  iodelay_tap_ctrl #(
    .num_lanes_p       (5),
    .tap_width_p       (5),
    .init_tap_p        (0),
    .rst_hold_cycles_p (16),
    .rdy_timeout_p     (32)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .idelayctrl_rdy_i  (rdy),
    .idelayctrl_rst_o  (rst_o),
    .idelay_ld_o       (ld_o),
    .idelay_cntvalue_o (cval_o),
    .idelay_cntvalue_i (cv_i),
    .cmd_v_i           (cmd_v),
    .cmd_lane_i        (cmd_lane),
    .cmd_tap_i         (cmd_tap),
    .cmd_ready_o       (cmd_ready),
    .resp_v_o          (resp_v),
    .resp_err_o        (resp_err),
    .resp_ready_i      (resp_ready),
    .calibrated_o      (cal),
    .timeout_err_o     (tmo)
  );

  // IDELAYE2 model: CNTVALUEOUT follows the last loaded value
  initial for (int i = 0; i < 5; i++) tap_m[i] = '0;

  always @(posedge clk)
    for (int i = 0; i < 5; i++)
      if (ld_o[i]) tap_m[i] <= cval_o;

  always_comb begin
    cv_i = '0;
    for (int i = 0; i < 5; i++)
      cv_i[i*5 +: 5] = (corrupt && i == 0) ? 5'd8 : tap_m[i];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_init(input int n);
    for (int i = 0; i < n; i++) ldq.push_back('{ld: 5'(1 << i), cv: 5'd0});
  endtask

  task automatic count_rst(input string nm);
    int n = 0;
    @(negedge clk);
    while (rst_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, 16);
  endtask

  task automatic wait_cal(input string nm);
    int n = 0;
    @(negedge clk);
    while (!cal && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(nm, cal, 1);
  endtask

  // Called at posedge+1 with the DUT in IDLE.
  task automatic do_cmd(input logic [2:0] lane, input logic [4:0] tap,
                        input logic [4:0] eld, input logic eerr,
                        input int hold);
    logic ok;
    cmd_v    = 1'b1;
    cmd_lane = lane;
    cmd_tap  = tap;
    if (eld != 0) ldq.push_back('{ld: eld, cv: tap});
    respq.push_back(eerr);
    @(negedge clk);
    chk("cmd_ready_t0", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_v = 1'b0;
    @(negedge clk);
    chk("ld_t1", ld_o, eld);
    chk("ready_t1", cmd_ready, 0);
    @(negedge clk);
    chk("resp_t2", resp_v, 0);
    @(negedge clk);
    chk("resp_t3", resp_v, 1);
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ok = ok & resp_v & (resp_err == eerr) & ~cmd_ready;
    end
    if (hold > 0) chk("resp_hold", ok, 1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("idle_again", cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (reset_n) begin
      if (ld_o != 0) begin
        if (ldq.size() == 0) chk("ld_unexpected", ld_o, 0);
        else begin
          e = ldq.pop_front();
          chk("sb_ld", ld_o, e.ld);
          chk("sb_cval", cval_o, e.cv);
        end
      end
      if (resp_v && resp_ready) begin
        if (respq.size() == 0) chk("resp_unexpected", resp_v, 0);
        else chk("sb_err", resp_err, respq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    rdy        = 1'b0;
    cmd_v      = 1'b0;
    cmd_lane   = '0;
    cmd_tap    = '0;
    resp_ready = 1'b0;
    corrupt    = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_rst_o", rst_o, 1);
    chk("rst_ld", ld_o, 0);
    chk("rst_cval", cval_o, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_resp", {resp_v, resp_err}, 0);
    chk("rst_cal_tmo", {cal, tmo}, 0);

    // Power-up: RST pulse, RDY after ~20 cycles, INIT sweep
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_init(5);
    count_rst("rst_hold");
    repeat (3) @(posedge clk);
    #1 rdy = 1'b1;
    n = 0;
    @(negedge clk);
    while (ld_o == 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("init_start", n < 100, 1);
    n = 0;
    while (ld_o != 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("init_len", n, 5);
    chk("init_cal", cal, 1);
    chk("init_tmo", tmo, 0);

    // Good load with held response, bad lane, readback mismatch
    @(posedge clk); #1;
    do_cmd(3'd2, 5'd13, 5'b00100, 1'b0, 5);
    do_cmd(3'd7, 5'd3, 5'b00000, 1'b1, 0);
    chk("cval_hold", cval_o, 13);
    corrupt = 1'b1;
    do_cmd(3'd0, 5'd9, 5'b00001, 1'b1, 0);
    corrupt = 1'b0;
    do_cmd(3'd4, 5'd31, 5'b10000, 1'b0, 0);

    // RDY loss while holding a response
    cmd_v    = 1'b1;
    cmd_lane = 3'd1;
    cmd_tap  = 5'd5;
    ldq.push_back('{ld: 5'b00010, cv: 5'd5});
    @(posedge clk); #1;
    cmd_v = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_v && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("rl_resp", resp_v, 1);
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rl_still", resp_v, 1);
    @(negedge clk);
    chk("rl_resp_drop", resp_v, 0);
    chk("rl_rst", rst_o, 1);
    chk("rl_cal", cal, 0);
    chk("rl_tmo", tmo, 0);
    tick(10);
    push_init(5);
    rdy = 1'b1;
    wait_cal("rl_recal");
    chk("rl_no_stale", resp_v, 0);

    // Async reset in the middle of INIT lane 3
    @(posedge clk); #1;
    push_init(4);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (ld_o != 5'b01000 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("ar_lane3", ld_o, 5'b01000);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_ld", ld_o, 0);
    chk("ar_rst", rst_o, 1);
    chk("ar_cal", cal, 0);
    tick(2);
    push_init(5);
    reset_n = 1'b1;
    count_rst("ar_rst_hold");
    wait_cal("ar_recal");

    // RDY stuck low: timeout, re-pulse, then recovery
    @(posedge clk); #1;
    rdy     = 1'b0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tmo && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 48);
    n = 0;
    while (rst_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_rst_repulse", n, 16);
    tick(40);
    push_init(5);
    rdy = 1'b1;
    wait_cal("to_recal");
    chk("to_sticky", tmo, 1);

    tick(2);
    chk("ldq_empty", ldq.size(), 0);
    chk("respq_empty", respq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
